// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, execute-sequencer state encodings and ALU op codes.
// CU_DONE is also watched by the fetch FSM to leave EXECUTE.
package cpu_pkg;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_AND   = 3'b011;
  localparam logic [2:0] OP_LOAD  = 3'b100;
  localparam logic [2:0] OP_STORE = 3'b101;
  localparam logic [2:0] OP_OR    = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  typedef enum logic [2:0] {
    CU_IDLE      = 3'b000,
    CU_READ_OPS  = 3'b001,
    CU_ALU       = 3'b010,
    CU_MEM_REQ   = 3'b011,
    CU_MEM_WAIT  = 3'b100,
    CU_WRITEBACK = 3'b101,
    CU_HALTED    = 3'b110,
    CU_DONE      = 3'b111
  } cu_state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

endpackage

// File: rtl/cu_decode.sv
// Combinational instruction decode: classifies the opcode and splits out register fields.
module cu_decode
  import cpu_pkg::*;
(
  input  logic [7:0] ir,
  output logic       is_alu,
  output logic       is_load,
  output logic       is_store,
  output logic       is_nop,
  output logic       is_halt,
  output logic [1:0] alu_op,
  output logic [1:0] rd,
  output logic [1:0] rs
);

  logic unused_rsvd;
  assign unused_rsvd = ir[0];

  assign rd = ir[4:3];
  assign rs = ir[2:1];

  always_comb begin
    is_alu   = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
    is_nop   = 1'b0;
    is_halt  = 1'b0;
    alu_op   = ALU_ADD;
    case (ir[7:5])
      OP_NOP:   is_nop = 1'b1;
      OP_ADD:   begin is_alu = 1'b1; alu_op = ALU_ADD; end
      OP_SUB:   begin is_alu = 1'b1; alu_op = ALU_SUB; end
      OP_AND:   begin is_alu = 1'b1; alu_op = ALU_AND; end
      OP_OR:    begin is_alu = 1'b1; alu_op = ALU_OR;  end
      OP_LOAD:  is_load = 1'b1;
      OP_STORE: is_store = 1'b1;
      default:  is_halt = 1'b1;
    endcase
  end

endmodule

// File: rtl/cu_sequencer.sv
// Execute-phase sequencer: walks one instruction through register read, ALU or RAM
// handshake and writeback, then pulses CU_DONE to release the fetch FSM.
module cu_sequencer
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       exec_en,
  input  logic [7:0] ir,
  input  logic       mem_ack,
  output logic [2:0] cu_state,
  output logic [1:0] rf_ra,
  output logic [1:0] rf_rb,
  output logic       op_latch,
  output logic [1:0] alu_op,
  output logic       mem_req,
  output logic       mem_we,
  output logic       rf_we,
  output logic [1:0] rf_wa,
  output logic       wb_sel,
  output logic       halted,
  output logic [7:0] instr_count
);

  cu_state_t  state, state_nxt;
  logic       exec_en_q;
  logic [7:0] ir_q;
  logic       start;

  logic       is_alu, is_load, is_store, is_nop, is_halt;
  logic [1:0] dec_alu_op, rd, rs;
  logic [7:0] dec_ir;

  // exec_en stays high for a cycle after DONE; only a rising edge may launch.
  assign start = exec_en & ~exec_en_q;

  // IDLE has to classify the incoming instruction before it lands in ir_q.
  assign dec_ir = (state == CU_IDLE) ? ir : ir_q;

  cu_decode u_dec (
    .ir       (dec_ir),
    .is_alu   (is_alu),
    .is_load  (is_load),
    .is_store (is_store),
    .is_nop   (is_nop),
    .is_halt  (is_halt),
    .alu_op   (dec_alu_op),
    .rd       (rd),
    .rs       (rs)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= CU_IDLE;
      exec_en_q   <= 1'b0;
      ir_q        <= 8'd0;
      instr_count <= 8'd0;
    end else begin
      state     <= state_nxt;
      exec_en_q <= exec_en;
      if (state == CU_IDLE && start) ir_q <= ir;
      if (state == CU_DONE) instr_count <= instr_count + 8'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CU_IDLE: begin
        if (start) begin
          if (is_nop)       state_nxt = CU_DONE;
          else if (is_halt) state_nxt = CU_HALTED;
          else              state_nxt = CU_READ_OPS;
        end
      end
      CU_READ_OPS:  state_nxt = is_alu ? CU_ALU : CU_MEM_REQ;
      CU_ALU:       state_nxt = CU_WRITEBACK;
      CU_MEM_REQ,
      CU_MEM_WAIT: begin
        if (mem_ack) state_nxt = is_load ? CU_WRITEBACK : CU_DONE;
        else         state_nxt = CU_MEM_WAIT;
      end
      CU_WRITEBACK: state_nxt = CU_DONE;
      CU_DONE:      state_nxt = CU_IDLE;
      CU_HALTED:    state_nxt = CU_HALTED;
      default:      state_nxt = CU_IDLE;
    endcase
  end

  always_comb begin
    rf_ra    = 2'd0;
    rf_rb    = 2'd0;
    op_latch = 1'b0;
    alu_op   = ALU_ADD;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    rf_we    = 1'b0;
    rf_wa    = 2'd0;
    wb_sel   = 1'b0;
    halted   = 1'b0;
    case (state)
      CU_READ_OPS: begin
        rf_ra    = rd;
        rf_rb    = rs;
        op_latch = 1'b1;
        alu_op   = dec_alu_op;
      end
      CU_ALU: alu_op = dec_alu_op;
      CU_MEM_REQ,
      CU_MEM_WAIT: begin
        mem_req = 1'b1;
        mem_we  = is_store;
      end
      CU_WRITEBACK: begin
        rf_we  = 1'b1;
        rf_wa  = rd;
        wb_sel = is_load;
        alu_op = dec_alu_op;
      end
      CU_HALTED: halted = 1'b1;
      default: ;
    endcase
  end

  assign cu_state = state;

endmodule
